// File: rtl/issue_scoreboard.sv
// Issue scoreboard: tracks outstanding register writes, stalls decode on RAW/WAW or write-cap
// hazards, holds one instruction in an issue register, and drains writebacks after a flush.
// Ports:
//   clk, rst (async, active-high)
//   i_dec_*            decode handshake and operand fields; o_dec_ready
//   o_issue_*          issue register to execute; i_issue_ready
//   i_wb_valid/i_wb_rd writeback completion
//   i_flush            single-cycle flush
//   o_busy_mask, o_inflight, o_stall, o_stall_cycles
// Optional feature: define ISSUE_SCOREBOARD_STALL_CNT_EN to enable the saturating
// STALL-cycle counter; otherwise o_stall_cycles is tied to 0.
module issue_scoreboard #(
  parameter int n_regs_p = 32,
  parameter int max_inflight_p = 4,
  parameter int wd_cnt_p = 16,
  localparam int wd_addr_p = $clog2(n_regs_p)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_dec_valid,
  output logic                 o_dec_ready,
  input  logic [wd_addr_p-1:0] i_dec_rs1,
  input  logic [wd_addr_p-1:0] i_dec_rs2,
  input  logic [wd_addr_p-1:0] i_dec_rd,
  input  logic                 i_dec_uses_rs1,
  input  logic                 i_dec_uses_rs2,
  input  logic                 i_dec_writes_rd,
  output logic                 o_issue_valid,
  input  logic                 i_issue_ready,
  output logic [wd_addr_p-1:0] o_issue_rd,
  output logic                 o_issue_writes,
  input  logic                 i_wb_valid,
  input  logic [wd_addr_p-1:0] i_wb_rd,
  input  logic                 i_flush,
  output logic [n_regs_p-1:0]  o_busy_mask,
  output logic [3:0]           o_inflight,
  output logic                 o_stall,
  output logic [wd_cnt_p-1:0]  o_stall_cycles
);

  localparam logic [4:0] MaxInfl = 5'(max_inflight_p);

  typedef enum logic [1:0] {
    RUN,
    STALL,
    DRAIN
  } state_e;

  state_e                state_q;
  logic [n_regs_p-1:0]   busy_q, busy_d;
  logic [3:0]            infl_q, infl_d;
  logic                  iv_q, iv_d;
  logic                  iw_q, iw_d;
  logic [wd_addr_p-1:0]  ird_q, ird_d;

  logic [n_regs_p-1:0]   issue_oh;
  logic [n_regs_p-1:0]   pend;
  logic                  pend_iss;
  logic [4:0]            load;
  logic                  rd_nz;
  logic                  hazard;
  logic                  dec_ready;
  logic                  accept;
  logic                  handoff;
  logic                  set_b;
  logic                  clr_b;

  // Pending = committed busy bits plus the rd still sitting in the issue register.
  always_comb begin
    issue_oh = '0;
    if (iv_q && iw_q) issue_oh[ird_q] = 1'b1;
    pend    = busy_q | issue_oh;
    pend[0] = 1'b0;
  end

  assign pend_iss = iv_q && iw_q;
  assign load     = {1'b0, infl_q} + {4'b0, pend_iss};
  assign rd_nz    = (i_dec_rd != '0);

  assign hazard = (i_dec_uses_rs1 && pend[i_dec_rs1])
                || (i_dec_uses_rs2 && pend[i_dec_rs2])
                || (i_dec_writes_rd && rd_nz && pend[i_dec_rd])
                || (i_dec_writes_rd && rd_nz && (load >= MaxInfl));

  assign dec_ready = !rst && (state_q != DRAIN) && !i_flush
                   && !hazard && (!iv_q || i_issue_ready);

  assign accept  = i_dec_valid && dec_ready;
  // Flush discards the held instruction, so it never reaches execute.
  assign handoff = iv_q && i_issue_ready && !i_flush;
  assign set_b   = handoff && iw_q;
  assign clr_b   = i_wb_valid && (i_wb_rd != '0) && busy_q[i_wb_rd];

  always_comb begin
    busy_d = busy_q;
    if (clr_b) busy_d[i_wb_rd] = 1'b0;
    // Applied after the clear so a same-cycle set to the same rd wins.
    if (set_b) busy_d[ird_q] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    infl_d = infl_q;
    unique case ({set_b, clr_b})
      2'b10:   infl_d = infl_q + 4'd1;
      2'b01:   infl_d = infl_q - 4'd1;
      default: infl_d = infl_q;
    endcase
  end

  always_comb begin
    iv_d  = iv_q;
    iw_d  = iw_q;
    ird_d = ird_q;
    if (i_flush) begin
      iv_d = 1'b0;
    end else if (accept) begin
      iv_d  = 1'b1;
      ird_d = i_dec_rd;
      iw_d  = i_dec_writes_rd && rd_nz;
    end else if (handoff) begin
      iv_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      busy_q  <= '0;
      infl_q  <= '0;
      iv_q    <= 1'b0;
      iw_q    <= 1'b0;
      ird_q   <= '0;
    end else begin
      busy_q <= busy_d;
      infl_q <= infl_d;
      iv_q   <= iv_d;
      iw_q   <= iw_d;
      ird_q  <= ird_d;
      unique case (state_q)
        RUN: begin
          if (i_flush) state_q <= DRAIN;
          else if (i_dec_valid && hazard) state_q <= STALL;
        end
        STALL: begin
          if (i_flush) state_q <= DRAIN;
          else if (!hazard) state_q <= RUN;
        end
        DRAIN: begin
          if (!i_flush && (infl_q == '0)) state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

`ifdef ISSUE_SCOREBOARD_STALL_CNT_EN
  logic [wd_cnt_p-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if ((state_q == STALL) && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_stall_cycles = cnt_q;
`else
  assign o_stall_cycles = '0;
`endif

  assign o_dec_ready    = dec_ready;
  assign o_issue_valid  = iv_q;
  assign o_issue_rd     = ird_q;
  assign o_issue_writes = iw_q;
  assign o_busy_mask    = busy_q;
  assign o_inflight     = infl_q;
  assign o_stall        = (state_q == STALL);

endmodule

// File: tb/tb_issue_scoreboard.sv
// Testbench for issue_scoreboard: directed decode/writeback/flush sequences,
// with issued instructions checked by a queue-based monitor at handoff.
module tb_issue_scoreboard;

  logic        clk;
  logic        rst;
  logic        dv;
  logic        dec_ready;
  logic [4:0]  rs1, rs2, rd;
  logic        u1, u2, w;
  logic        iv;
  logic        ir;
  logic [4:0]  ird;
  logic        iwr;
  logic        wbv;
  logic [4:0]  wbrd;
  logic        flush;
  logic [31:0] busy;
  logic [3:0]  infl;
  logic        stall;
  logic [15:0] scyc;

  int errors = 0;
  int checks = 0;
  logic [5:0] exp_q[$];

  issue_scoreboard dut (
    .clk            (clk),
    .rst            (rst),
    .i_dec_valid    (dv),
    .o_dec_ready    (dec_ready),
    .i_dec_rs1      (rs1),
    .i_dec_rs2      (rs2),
    .i_dec_rd       (rd),
    .i_dec_uses_rs1 (u1),
    .i_dec_uses_rs2 (u2),
    .i_dec_writes_rd(w),
    .o_issue_valid  (iv),
    .i_issue_ready  (ir),
    .o_issue_rd     (ird),
    .o_issue_writes (iwr),
    .i_wb_valid     (wbv),
    .i_wb_rd        (wbrd),
    .i_flush        (flush),
    .o_busy_mask    (busy),
    .o_inflight     (infl),
    .o_stall        (stall),
    .o_stall_cycles (scyc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every handoff to execute must match the oldest expected issue.
  always @(negedge clk) begin
    if (!rst && iv && ir && !flush) begin
      logic [5:0] e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL issue_unexpected: got rd=%0d with nothing expected", ird);
      end else begin
        e = exp_q.pop_front();
        chk("issue_rd", 32'(ird), 32'(e[4:0]));
        chk("issue_writes", 32'(iwr), 32'(e[5]));
      end
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] a1, input logic [4:0] a2,
                      input logic [4:0] d, input logic e1,
                      input logic e2, input logic wr);
    bit ok;
    ok  = 1'b0;
    dv  = 1'b1;
    rs1 = a1;
    rs2 = a2;
    rd  = d;
    u1  = e1;
    u2  = e2;
    w   = wr;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dec_ready) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_accept: rd=%0d not accepted within 20 cycles", d);
    end else begin
      exp_q.push_back({wr && (d != 5'd0), d});
    end
    cyc();
    dv = 1'b0;
    u1 = 1'b0;
    u2 = 1'b0;
    w  = 1'b0;
  endtask

  task automatic wb(input logic [4:0] r);
    wbv  = 1'b1;
    wbrd = r;
    cyc();
    wbv  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    dv = 0; rs1 = 0; rs2 = 0; rd = 0;
    u1 = 0; u2 = 0; w = 0;
    ir = 1'b1;
    wbv = 0; wbrd = 0; flush = 0;

    // Reset state
    @(negedge clk);
    chk("rst_busy", busy, 32'h0);
    chk("rst_infl", 32'(infl), 0);
    chk("rst_iv", 32'(iv), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_ready", 32'(dec_ready), 0);
    chk("rst_scyc", 32'(scyc), 0);
    cyc();
    rst = 1'b0;

    // Back-to-back independent rd=5, rd=6
    dv = 1; rd = 5; w = 1;
    exp_q.push_back({1'b1, 5'd5});
    @(negedge clk);
    chk("b2b_ready0", 32'(dec_ready), 1);
    cyc();
    rd = 6;
    exp_q.push_back({1'b1, 5'd6});
    @(negedge clk);
    chk("b2b_iv1", 32'(iv), 1);
    chk("b2b_ready1", 32'(dec_ready), 1);
    cyc();
    dv = 0; w = 0;
    @(negedge clk);
    chk("b2b_busy1", busy, 32'h20);
    cyc();
    @(negedge clk);
    chk("b2b_busy2", busy, 32'h60);
    chk("b2b_infl", 32'(infl), 2);
    chk("b2b_stall", 32'(stall), 0);
    chk("b2b_iv_idle", 32'(iv), 0);
    cyc();
    wb(5);
    wb(6);
    @(negedge clk);
    chk("b2b_drained", 32'(infl), 0);
    cyc();

    // RAW stall on x3
    send(0, 0, 3, 0, 0, 1);
    cyc();
    dv = 1; u1 = 1; rs1 = 3; rd = 10; w = 1;
    @(negedge clk);
    chk("raw_ready0", 32'(dec_ready), 0);
    cyc();
    @(negedge clk);
    chk("raw_stall", 32'(stall), 1);
    cyc();
    wbv = 1; wbrd = 3;
    @(negedge clk);
    chk("raw_nobypass", 32'(dec_ready), 0);
    cyc();
    wbv = 0;
    @(negedge clk);
    chk("raw_busy_clr", busy, 32'h0);
    chk("raw_ready1", 32'(dec_ready), 1);
    exp_q.push_back({1'b1, 5'd10});
    cyc();
    dv = 0; u1 = 0; w = 0;
    @(negedge clk);
    chk("raw_run", 32'(stall), 0);
`ifdef ISSUE_SCOREBOARD_STALL_CNT_EN
    chk("raw_scyc", 32'(scyc), 3);
`else
    chk("raw_scyc", 32'(scyc), 0);
`endif
    cyc();
    @(negedge clk);
    chk("raw_busy10", busy, 32'h400);
    cyc();
    wb(10);

    // x0 rules
    send(0, 0, 0, 1, 0, 1);
    cyc();
    @(negedge clk);
    chk("x0_busy", busy, 32'h0);
    chk("x0_infl", 32'(infl), 0);
    cyc();

    // Inflight cap
    for (int r = 1; r <= 4; r++) send(0, 0, 5'(r), 0, 0, 1);
    dv = 1; rd = 7; w = 1;
    @(negedge clk);
    chk("cap_ready0", 32'(dec_ready), 0);
    cyc();
    @(negedge clk);
    chk("cap_stall", 32'(stall), 1);
    chk("cap_infl4", 32'(infl), 4);
    cyc();
    rd = 0; w = 0; u1 = 1; rs1 = 8;
    @(negedge clk);
    chk("cap_reader_ok", 32'(dec_ready), 1);
    exp_q.push_back({1'b0, 5'd0});
    cyc();
    dv = 0; u1 = 0;
    @(negedge clk);
    chk("cap_busy", busy, 32'h1E);
    cyc();
    wb(9);
    @(negedge clk);
    chk("wb_nonbusy_infl", 32'(infl), 4);
    chk("wb_nonbusy_busy", busy, 32'h1E);
    cyc();
    for (int r = 1; r <= 4; r++) wb(5'(r));
    @(negedge clk);
    chk("cap_drained", 32'(infl), 0);
    cyc();

    // Simultaneous handoff rd=4 and writeback rd=2
    send(0, 0, 2, 0, 0, 1);
    cyc();
    ir = 0;
    send(0, 0, 4, 0, 0, 1);
    ir = 1; wbv = 1; wbrd = 2;
    cyc();
    wbv = 0;
    @(negedge clk);
    chk("sim_infl", 32'(infl), 1);
    chk("sim_busy", busy, 32'h10);
    cyc();
    wb(4);

    // Flush with rd=9 held and two writes outstanding
    send(0, 0, 11, 0, 0, 1);
    send(0, 0, 12, 0, 0, 1);
    cyc();
    ir = 0;
    send(0, 0, 9, 0, 0, 1);
    flush = 1; dv = 1; rd = 13; w = 1;
    @(negedge clk);
    chk("fl_ready_flush", 32'(dec_ready), 0);
    cyc();
    void'(exp_q.pop_back());
    flush = 0; dv = 0; w = 0; ir = 1;
    @(negedge clk);
    chk("fl_iv", 32'(iv), 0);
    chk("fl_busy", busy, 32'h1800);
    chk("fl_ready_drain", 32'(dec_ready), 0);
    chk("fl_infl", 32'(infl), 2);
    cyc();
    wb(11);
    wb(12);
    @(negedge clk);
    chk("fl_infl0", 32'(infl), 0);
    chk("fl_still_drain", 32'(dec_ready), 0);
    cyc();
    @(negedge clk);
    chk("fl_run", 32'(dec_ready), 1);
    cyc();

    // Reset mid-operation, late writeback ignored
    send(0, 0, 20, 0, 0, 1);
    cyc();
    rst = 1;
    @(negedge clk);
    chk("mrst_busy", busy, 32'h0);
    chk("mrst_infl", 32'(infl), 0);
    chk("mrst_scyc", 32'(scyc), 0);
    cyc();
    rst = 0;
    wb(20);
    @(negedge clk);
    chk("mrst_wb_ign", 32'(infl), 0);
    chk("mrst_wb_busy", busy, 32'h0);

    repeat (3) cyc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL issue_leftover: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
